// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types, sizes and row-to-bit mapping for the truth-table sweeper
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

  localparam int TT_ROWS   = 16;
  localparam int TT_INPUTS = 4;

  // Row 0 lands in the MSB so the code reads like the circuit design names.
  function automatic logic [3:0] row_to_bit(input logic [3:0] r);
    return 4'd15 - r;
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// rtl/tt_sync2.sv - two-flop synchronizer, resets to 0
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the asynchronous input time to resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps 16 input rows of a 4-input circuit and captures its truth table (option: TT_COMPARE_EN)
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  input  logic        out_sense,
  output logic [15:0] code,
  output logic        glitch
`ifdef TT_COMPARE_EN
  ,
  input  logic [15:0] expected,
  output logic        mismatch
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int NW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int OW = $clog2(SAMPLES + 1);

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] SAMPLE_LOAD = NW'(SAMPLES - 1);
  localparam logic [OW-1:0] SAMPLES_W   = OW'(SAMPLES);
  localparam logic [OW-1:0] MAJORITY    = OW'(SAMPLES / 2);
  localparam logic [TT_INPUTS-1:0] LAST_ROW = TT_INPUTS'(TT_ROWS - 1);

  tt_state_e            state_q, state_d;
  logic [TT_INPUTS-1:0] row_q, row_d;
  logic [TT_INPUTS-1:0] stim_q, stim_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [NW-1:0]        samp_q, samp_d;
  logic [OW-1:0]        ones_q, ones_d;
  logic [OW-1:0]        ones_total;
  logic [15:0]          code_q, code_d;
  logic                 glitch_q, glitch_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sense_sync;
`ifdef TT_COMPARE_EN
  logic                 mismatch_q, mismatch_d;
`endif

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_sense),
    .q     (sense_sync)
  );

  // Next-state and output decode: settle each row, majority-sample, then advance.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    stim_d     = stim_q;
    settle_d   = settle_q;
    samp_d     = samp_q;
    ones_d     = ones_q;
    code_d     = code_q;
    glitch_d   = glitch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ones_total = ones_q + OW'(sense_sync);
`ifdef TT_COMPARE_EN
    mismatch_d = mismatch_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d    = '0;
          stim_d   = '0;
          code_d   = '0;
          glitch_d = 1'b0;
          busy_d   = 1'b1;
          settle_d = SETTLE_LOAD;
          state_d  = ST_SETTLE;
`ifdef TT_COMPARE_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          samp_d  = SAMPLE_LOAD;
          ones_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_SAMPLE: begin
        ones_d = ones_total;
        if (samp_q == '0) begin
          code_d[row_to_bit(row_q)] = (ones_total > MAJORITY);
          if ((ones_total != '0) && (ones_total != SAMPLES_W)) begin
            glitch_d = 1'b1;
          end
          if (row_q == LAST_ROW) begin
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
`ifdef TT_COMPARE_EN
            mismatch_d = (code_d != expected);
`endif
          end else begin
            row_d    = row_q + 1'b1;
            stim_d   = row_q + 1'b1;
            settle_d = SETTLE_LOAD;
            state_d  = ST_SETTLE;
          end
        end else begin
          samp_d = samp_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      stim_q   <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      ones_q   <= '0;
      code_q   <= '0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TT_COMPARE_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      ones_q   <= ones_d;
      code_q   <= code_d;
      glitch_q <= glitch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TT_COMPARE_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign {in1, in2, in3, in4} = stim_q;
  assign code   = code_q;
  assign glitch = glitch_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef TT_COMPARE_EN
  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper with modelled circuits
module tb_truth_table_sweeper;

  localparam int LATENCY = 177;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, in1, in2, in3, in4, glitch;
  logic        out_sense;
  logic [15:0] code;
  logic [15:0] expected_r;
  logic        mismatch;

  int          mode;
  int          delay;
  logic [15:0] tbl;
  logic [7:0]  dly;
  logic        f;
  logic        inj;
  logic        inj_arm;
  int          inj_cnt;
  int          cyc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] code;
    logic        glitch;
    logic        mm;
    int          t0;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  truth_table_sweeper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .out_sense (out_sense),
    .code      (code),
    .glitch    (glitch)
`ifdef TT_COMPARE_EN
    ,
    .expected  (expected_r),
    .mismatch  (mismatch)
`endif
  );

`ifndef TT_COMPARE_EN
  assign mismatch = 1'b0;
`endif

  // Circuit under test models
  always_comb begin
    case (mode)
      0:       f = in1;
      1:       f = ~(in1 | in2 | in3 | in4);
      2:       f = 1'b1;
      default: f = tbl[4'd15 - {in1, in2, in3, in4}];
    endcase
  end

  always @(posedge clk) begin
    dly <= {dly[6:0], f};
    cyc <= cyc + 1;
  end

  always_comb begin
    if (delay == 0) out_sense = f & ~inj;
    else            out_sense = dly[delay-1] & ~inj;
  end

  // One-cycle dropout of the circuit output inside the row-3 sample window
  always @(negedge clk) begin
    if (inj_arm && ({in1, in2, in3, in4} == 4'd3)) begin
      inj_cnt = inj_cnt + 1;
      if (inj_cnt == 8) inj = 1'b1;
      else if (inj_cnt == 9) begin
        inj     = 1'b0;
        inj_arm = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("code", 32'(code), 32'(e.code));
        check("glitch", 32'(glitch), 32'(e.glitch));
        check("latency", 32'(cyc - e.t0), 32'(LATENCY));
`ifdef TT_COMPARE_EN
        check("mismatch", 32'(mismatch), 32'(e.mm));
`endif
      end
    end
  end

  task automatic issue(input logic [15:0] c, input logic g, input logic m);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e.code = c; e.glitch = g; e.mm = m; e.t0 = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", budget);
      sb_q.delete();
    end else begin
      check("busy_at_done", 32'(busy), 32'd0);
      check("stim_at_done", 32'({in1, in2, in3, in4}), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 0; delay = 0; tbl = 16'h0;
    expected_r = 16'h0; inj = 1'b0; inj_arm = 1'b0; inj_cnt = 0; cyc = 0; dly = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stim", 32'({in1, in2, in3, in4}), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_glitch", 32'(glitch), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // out = in1
    mode = 0; delay = 0;
    issue(16'h00FF, 1'b0, 1'b0);
    wait_done(400);

    // NOR with 5-cycle output delay, started one cycle after previous done
    mode = 1; delay = 5;
    issue(16'h8000, 1'b0, 1'b0);
    wait_done(400);
    check("code_held", 32'(code), 32'h8000);

    // constant 1 with one bad sample in row 3
    mode = 2; delay = 0; inj_cnt = 0; inj_arm = 1'b1;
    issue(16'hFFFF, 1'b1, 1'b0);
    wait_done(400);
    inj_arm = 1'b0;

    // second start mid-sweep is ignored
    mode = 0;
    issue(16'h00FF, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // reset mid-sweep at cycle 60
    mode = 2;
    issue(16'hFFFF, 1'b0, 1'b0);
    repeat (58) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_stim", 32'({in1, in2, in3, in4}), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_glitch", 32'(glitch), 32'd0);
    sb_q.delete();
    rst_n = 1'b1;
    mode = 0;
    issue(16'h00FF, 1'b0, 1'b0);
    wait_done(400);

`ifdef TT_COMPARE_EN
    mode = 3; tbl = 16'hE93A; expected_r = 16'hE93A;
    issue(16'hE93A, 1'b0, 1'b0);
    wait_done(400);
    expected_r = 16'hE93B;
    issue(16'hE93A, 1'b0, 1'b1);
    wait_done(400);
    check("mismatch_held", 32'(mismatch), 32'd1);
    expected_r = 16'hE93A;
    issue(16'hE93A, 1'b0, 1'b0);
    check("mismatch_cleared", 32'(mismatch), 32'd0);
    wait_done(400);
`endif

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL leftover: got %0d pending results expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
